// File: rtl/qnet_pkg.sv
// rtl/qnet_pkg.sv - shared QNET types, state-code encoding and trace constants
//
// Contents:
//   type_qnet_cmd_e  - QNET command FSM states
//   qnet_st_encode() - maps a command state to its 6-bit trace code
//   trace_st_e       - capture FSM of the state-transition tracer
//   QNET_DBG_FILL    - code shown in history slots that were never written

package qnet_pkg;

    localparam int              QNET_ST_W     = 6;
    localparam logic [5:0]      ST_ERROR      = 6'd63;
    localparam int              QNET_DBG_FILL = 62;

    typedef enum logic [2:0] {
        QNET_CMD_IDLE,
        QNET_CMD_FETCH,
        QNET_CMD_DECODE,
        QNET_CMD_EXEC,
        QNET_CMD_RESP,
        QNET_CMD_ABORT
    } type_qnet_cmd_e;

    typedef enum logic [1:0] {
        TRACE_RUN,
        TRACE_POST,
        TRACE_FROZEN
    } trace_st_e;

    // Any encoding outside the defined command set traces as ST_ERROR so a
    // corrupted state register is visible in the history.
    function automatic logic [QNET_ST_W-1:0] qnet_st_encode(input type_qnet_cmd_e cmd);
        logic [QNET_ST_W-1:0] code;
        case (cmd)
            QNET_CMD_IDLE:   code = 6'd0;
            QNET_CMD_FETCH:  code = 6'd1;
            QNET_CMD_DECODE: code = 6'd2;
            QNET_CMD_EXEC:   code = 6'd3;
            QNET_CMD_RESP:   code = 6'd4;
            QNET_CMD_ABORT:  code = 6'd5;
            default:         code = ST_ERROR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/qnet_trace_hist.sv
// rtl/qnet_trace_hist.sv - DEPTH-entry state-code/dwell history with registered readout
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   clear          - flush history; entry0 takes new_code
//   shift          - push new_code into entry0, old entry0 moves to entry1
//   new_code       - code written into entry0 on shift/clear
//   shift_dwell    - dwell stored with the old entry0 when it moves to entry1
//   live_dwell     - running dwell, reported as entry0's dwell
//   rd_idx         - readout index, 0 is newest
//   rd_code/dwell  - registered readout (one cycle after rd_idx)
//   head_codes     - codes of the newest PACK_N entries for the debug word

module qnet_trace_hist #(
    parameter int ST_W     = 6,
    parameter int TS_W     = 16,
    parameter int DEPTH    = 8,
    parameter int PACK_N   = 5,
    parameter int RST_CODE = 62,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          shift,
    input  logic [ST_W-1:0]               new_code,
    input  logic [TS_W-1:0]               shift_dwell,
    input  logic [TS_W-1:0]               live_dwell,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [ST_W-1:0]               rd_code,
    output logic [TS_W-1:0]               rd_dwell,
    output logic [PACK_N-1:0][ST_W-1:0]   head_codes
);

    localparam logic [ST_W-1:0] FILL = ST_W'(RST_CODE);

    logic [ST_W-1:0] code_q  [DEPTH];
    // entry0's dwell is always the live counter, so only 1..DEPTH-1 are stored
    logic [TS_W-1:0] dwell_q [1:DEPTH-1];
    logic [TS_W-1:0] dwell_view [DEPTH];
    logic [ST_W-1:0] rd_code_d;
    logic [TS_W-1:0] rd_dwell_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q[0] <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                code_q[k]  <= FILL;
                dwell_q[k] <= '0;
            end
        end else if (clear) begin
            code_q[0] <= new_code;
            for (int k = 1; k < DEPTH; k++) begin
                code_q[k]  <= FILL;
                dwell_q[k] <= '0;
            end
        end else if (shift) begin
            for (int k = DEPTH - 1; k >= 2; k--) begin
                code_q[k]  <= code_q[k-1];
                dwell_q[k] <= dwell_q[k-1];
            end
            code_q[1]  <= code_q[0];
            dwell_q[1] <= shift_dwell;
            code_q[0]  <= new_code;
        end
    end

    always_comb begin
        dwell_view[0] = live_dwell;
        for (int k = 1; k < DEPTH; k++) begin
            dwell_view[k] = dwell_q[k];
        end
    end

    // Indices past the end only exist when DEPTH is not a power of two.
    always_comb begin
        rd_code_d  = FILL;
        rd_dwell_d = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_code_d  = code_q[rd_idx];
            rd_dwell_d = dwell_view[rd_idx];
        end
    end

    // Sampled from the pre-edge contents, so a read during a shift sees the
    // history as it was before that shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_code  <= '0;
            rd_dwell <= '0;
        end else begin
            rd_code  <= rd_code_d;
            rd_dwell <= rd_dwell_d;
        end
    end

    always_comb begin
        for (int i = 0; i < PACK_N; i++) begin
            head_codes[i] = code_q[i];
        end
    end

endmodule

// File: rtl/qnet_st_trace.sv
// rtl/qnet_st_trace.sv - FSM state-transition tracer with trigger/freeze capture
//
// Ports:
//   st_clk_i, st_rst_ni      - clock, asynchronous active-low reset
//   current_st_i, next_st_i  - observed FSM state codes; a difference is a change
//   clear_i                  - re-arm capture and flush history
//   trig_en_i, trig_code_i   - trigger when a recorded change enters trig_code_i
//   post_n_i                 - changes still recorded after the trigger
//   rd_idx_i                 - history readout index (0 newest)
//   rd_code_o, rd_dwell_o    - readout, one cycle latency
//   debug_dt_o               - newest PACK_N codes packed, entry0 in the MSBs
//   trans_cnt_o              - changes since clear, saturating
//   ovf_o, frozen_o, trig_o  - history overflow, capture frozen, trigger fired

module qnet_st_trace
    import qnet_pkg::*;
#(
    parameter int ST_W     = 6,
    parameter int DEPTH    = 8,
    parameter int TS_W     = 16,
    parameter int PACK_N   = 5,
    parameter int RST_CODE = QNET_DBG_FILL,
    parameter int CNT_W    = 16
) (
    input  logic                       st_clk_i,
    input  logic                       st_rst_ni,
    input  logic [ST_W-1:0]            current_st_i,
    input  logic [ST_W-1:0]            next_st_i,
    input  logic                       clear_i,
    input  logic                       trig_en_i,
    input  logic [ST_W-1:0]            trig_code_i,
    input  logic [7:0]                 post_n_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [ST_W-1:0]            rd_code_o,
    output logic [TS_W-1:0]            rd_dwell_o,
    output logic [31:0]                debug_dt_o,
    output logic [CNT_W-1:0]           trans_cnt_o,
    output logic                       ovf_o,
    output logic                       frozen_o,
    output logic                       trig_o
);

    localparam logic [CNT_W-1:0] OVF_TH = CNT_W'(DEPTH - 1);

    trace_st_e               st_q, st_d;
    logic [7:0]              post_q, post_d;
    logic [TS_W-1:0]         dwell_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
    logic                    change;
    logic                    rec;
    logic                    trig_hit;
    logic [PACK_N-1:0][ST_W-1:0] head_codes;
    logic [31:0]             dbg;

    assign change   = (current_st_i != next_st_i);
    // A change is recorded only while capture is open; clear overrides it.
    assign rec      = change && (st_q != TRACE_FROZEN) && !clear_i;
    assign trig_hit = trig_en_i && (next_st_i == trig_code_i);

    always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
        if (!st_rst_ni) begin
            st_q   <= TRACE_RUN;
            post_q <= '0;
        end else begin
            st_q   <= st_d;
            post_q <= post_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        post_d = post_q;
        if (clear_i) begin
            st_d   = TRACE_RUN;
            post_d = '0;
        end else if (rec) begin
            case (st_q)
                TRACE_RUN: begin
                    if (trig_hit) begin
                        if (post_n_i == 8'd0) begin
                            st_d = TRACE_FROZEN;
                        end else begin
                            st_d   = TRACE_POST;
                            post_d = post_n_i;
                        end
                    end
                end
                TRACE_POST: begin
                    post_d = post_q - 8'd1;
                    if (post_q <= 8'd1) begin
                        st_d = TRACE_FROZEN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Dwell restarts on every recorded change and holds while frozen.
    always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
        if (!st_rst_ni) begin
            dwell_q <= '0;
        end else if (clear_i || rec) begin
            dwell_q <= '0;
        end else if (!change && (st_q != TRACE_FROZEN) && (dwell_q != '1)) begin
            dwell_q <= dwell_q + TS_W'(1);
        end
    end

    // The transition count keeps running while frozen; overflow does not,
    // because a frozen history can no longer lose entries.
    always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
        if (!st_rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (change) begin
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((st_q != TRACE_FROZEN) && (cnt_q >= OVF_TH)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    qnet_trace_hist #(
        .ST_W     (ST_W),
        .TS_W     (TS_W),
        .DEPTH    (DEPTH),
        .PACK_N   (PACK_N),
        .RST_CODE (RST_CODE)
    ) u_hist (
        .clk         (st_clk_i),
        .rst_n       (st_rst_ni),
        .clear       (clear_i),
        .shift       (rec),
        .new_code    (next_st_i),
        .shift_dwell (dwell_q),
        .live_dwell  (dwell_q),
        .rd_idx      (rd_idx_i),
        .rd_code     (rd_code_o),
        .rd_dwell    (rd_dwell_o),
        .head_codes  (head_codes)
    );

    always_comb begin
        dbg = '0;
        for (int i = 0; i < PACK_N; i++) begin
            dbg[(PACK_N-1-i)*ST_W +: ST_W] = head_codes[i];
        end
    end

    assign debug_dt_o  = dbg;
    assign trans_cnt_o = cnt_q;
    assign ovf_o       = ovf_q;
    // Only a trigger can move the FSM out of RUN, and only clear brings it back.
    assign frozen_o    = (st_q == TRACE_FROZEN);
    assign trig_o      = (st_q != TRACE_RUN);

endmodule

// File: tb/tb_qnet_st_trace.sv
// tb/tb_qnet_st_trace.sv - scoreboard bench for qnet_st_trace against a queue-based history model

module tb_qnet_st_trace;

    localparam int DEPTH = 8;
    localparam int FILL  = 62;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  current_st = '0;
    logic [5:0]  next_st = '0;
    logic        clear = 1'b0;
    logic        trig_en = 1'b0;
    logic [5:0]  trig_code = '0;
    logic [7:0]  post_n = '0;
    logic [2:0]  rd_idx = '0;
    logic [5:0]  rd_code;
    logic [15:0] rd_dwell;
    logic [31:0] debug_dt;
    logic [15:0] trans_cnt;
    logic        ovf;
    logic        frozen;
    logic        trig;

    qnet_st_trace dut (
        .st_clk_i     (clk),
        .st_rst_ni    (rst_n),
        .current_st_i (current_st),
        .next_st_i    (next_st),
        .clear_i      (clear),
        .trig_en_i    (trig_en),
        .trig_code_i  (trig_code),
        .post_n_i     (post_n),
        .rd_idx_i     (rd_idx),
        .rd_code_o    (rd_code),
        .rd_dwell_o   (rd_dwell),
        .debug_dt_o   (debug_dt),
        .trans_cnt_o  (trans_cnt),
        .ovf_o        (ovf),
        .frozen_o     (frozen),
        .trig_o       (trig)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned code;
        int unsigned dwell;
        int unsigned dbg;
        int unsigned cnt;
        int unsigned ovf;
        int unsigned frozen;
        int unsigned trig;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: history as queues, newest first.
    int m_code[$];
    int m_dwell[$];
    int m_live, m_cnt, m_left;
    bit m_ovf, m_trig, m_frozen;
    int cur_s = 0;

    function automatic void model_fill(input int head);
        m_code.delete();
        m_dwell.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_code.push_back(i == 0 ? head : FILL);
            m_dwell.push_back(0);
        end
        m_live = 0; m_cnt = 0; m_left = 0;
        m_ovf = 0; m_trig = 0; m_frozen = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
        end
    endtask

    // Drives one clock cycle: inputs set away from the edge, expectation queued.
    task automatic cycle(input int cur, input int nxt, input bit clr, input int idx);
        exp_t e;
        int d;
        bit chg;
        current_st = 6'(cur);
        next_st    = 6'(nxt);
        clear      = clr;
        rd_idx     = 3'(idx);
        e.code  = m_code[idx];
        e.dwell = (idx == 0) ? m_live : m_dwell[idx];
        chg = (cur != nxt);
        if (clr) begin
            model_fill(nxt);
        end else begin
            if (chg) begin
                if (!m_frozen && m_cnt >= DEPTH - 1) m_ovf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (chg && !m_frozen) begin
                m_dwell[0] = m_live;
                m_code.push_front(nxt);
                m_dwell.push_front(0);
                void'(m_code.pop_back());
                void'(m_dwell.pop_back());
                m_live = 0;
                if (m_trig) begin
                    m_left--;
                    if (m_left == 0) m_frozen = 1;
                end else if (trig_en && nxt == int'(trig_code)) begin
                    m_trig = 1;
                    m_left = int'(post_n);
                    if (m_left == 0) m_frozen = 1;
                end
            end else if (!chg && !m_frozen && m_live < 65535) begin
                m_live++;
            end
        end
        d = 0;
        for (int i = 0; i < 5; i++) d = (d << 6) | m_code[i];
        e.dbg = d; e.cnt = m_cnt; e.ovf = m_ovf; e.frozen = m_frozen; e.trig = m_trig;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic go(input int nxt);
        cycle(cur_s, nxt, 1'b0, $urandom_range(0, DEPTH - 1));
        cur_s = nxt;
    endtask

    task automatic hold(input int n);
        repeat (n) cycle(cur_s, cur_s, 1'b0, $urandom_range(0, DEPTH - 1));
    endtask

    task automatic do_clear(input int nxt);
        cycle(cur_s, nxt, 1'b1, $urandom_range(0, DEPTH - 1));
        cur_s = nxt;
    endtask

    int n_printed = 0;

    task automatic mon_cmp(input string name, input int unsigned act, input int unsigned expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            if (n_printed < 30) begin
                n_printed++;
                $display("FAIL mon_%s: got %0d, expected %0d at %0t", name, act, expv, $time);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mon_cmp("rd_code",   rd_code,   e.code);
                mon_cmp("rd_dwell",  rd_dwell,  e.dwell);
                mon_cmp("debug_dt",  debug_dt,  e.dbg);
                mon_cmp("trans_cnt", trans_cnt, e.cnt);
                mon_cmp("ovf",       ovf,       e.ovf);
                mon_cmp("frozen",    frozen,    e.frozen);
                mon_cmp("trig",      trig,      e.trig);
            end
        end
    end

    initial begin : stim
        int nxt;
        model_fill(0);
        repeat (2) @(negedge clk);
        chk("rst_debug_dt", debug_dt, 32'h00FBEFBE);
        chk("rst_trans_cnt", trans_cnt, 0);
        chk("rst_flags", {ovf, frozen, trig}, 0);
        chk("rst_rd", {rd_code, rd_dwell}, 0);
        rst_n = 1'b1;

        cycle(0, 0, 1'b0, 3);
        chk("rd_idx3_fill", rd_code, FILL);

        // 1 -> 2 -> 3 with holds of 10 and 4 cycles
        do_clear(1);
        hold(10);
        go(2);
        hold(4);
        go(3);
        chk("seq_cnt", trans_cnt, 2);
        chk("seq_ovf", ovf, 0);
        chk("seq_heads", debug_dt[29:12], {6'd3, 6'd2, 6'd1});
        cycle(3, 3, 1'b0, 1);
        chk("seq_e1", {rd_code, rd_dwell}, {6'd2, 16'd4});
        cycle(3, 3, 1'b0, 2);
        chk("seq_e2", {rd_code, rd_dwell}, {6'd1, 16'd10});

        // nine changes into an eight-entry history
        do_clear(20);
        for (int i = 1; i <= 9; i++) begin
            go(20 + i);
            hold(1);
            if (i == 7) chk("ovf_after7", ovf, 0);
            if (i == 8) chk("ovf_after8", ovf, 1);
        end
        chk("ovf_cnt9", trans_cnt, 9);
        cycle(cur_s, cur_s, 1'b0, 7);
        chk("ovf_oldest", rd_code, 22);

        // trigger on 42 with a two-change post window
        trig_en = 1'b1; trig_code = 6'd42; post_n = 8'd2;
        do_clear(1);
        hold(3);
        go(42);
        chk("trig_fired", {trig, frozen}, 2'b10);
        hold(2);
        go(7);
        hold(2);
        go(9);
        chk("trig_frozen", frozen, 1);
        hold(2);
        go(11);
        hold(3);
        chk("trig_head", debug_dt[29:24], 9);
        chk("trig_cnt", trans_cnt, 4);
        for (int i = 0; i < DEPTH; i++) cycle(cur_s, cur_s, 1'b0, i);
        trig_en = 1'b0;

        // dwell saturation
        do_clear(3);
        hold(65600);
        cycle(cur_s, cur_s, 1'b0, 0);
        chk("dwell_sat", rd_dwell, 16'hFFFF);

        // immediate freeze with post_n = 0, then clear together with a change
        trig_en = 1'b1; trig_code = 6'd50; post_n = 8'd0;
        for (int i = 0; i < 8; i++) go(10 + i);
        go(50);
        chk("post0_frozen", {trig, frozen, ovf}, 3'b111);
        go(51);
        do_clear(5);
        chk("clr_cnt", trans_cnt, 0);
        chk("clr_flags", {ovf, frozen, trig}, 0);
        chk("clr_dbg", debug_dt, {2'b0, 6'd5, 6'd62, 6'd62, 6'd62, 6'd62});
        trig_en = 1'b0;
        go(50);
        chk("trig_disabled", trig, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (n % 50 == 0) begin
                trig_en   = ($urandom_range(0, 1) == 1);
                trig_code = 6'($urandom_range(0, 7));
                post_n    = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) < 2) begin
                do_clear($urandom_range(0, 15));
            end else if ($urandom_range(0, 3) == 0) begin
                nxt = $urandom_range(0, 15);
                if (nxt == cur_s) nxt = (nxt + 1) % 16;
                go(nxt);
            end else begin
                hold(1);
            end
        end

        // reset in the middle of a post-trigger window
        trig_en = 1'b1; trig_code = 6'd33; post_n = 8'd5;
        do_clear(1);
        go(33);
        go(34);
        chk("midpost_state", {trig, frozen}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("midpost_rst_flags", {ovf, frozen, trig}, 0);
        chk("midpost_rst_cnt", trans_cnt, 0);
        chk("midpost_rst_dbg", debug_dt, 32'h00FBEFBE);
        chk("midpost_rst_rd", {rd_code, rd_dwell}, 0);
        model_fill(0);
        #1;
        rst_n = 1'b1;
        cur_s = 0;
        trig_en = 1'b0;
        go(4);
        hold(2);
        chk("post_rst_run", {trig, frozen}, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/qnet_st_trace.md
Name: qnet_st_trace

Overview:
- Parametrised state-transition tracer for the QNET command FSM and any other FSM that exposes a current/next state code.
- Keeps a DEPTH-deep history of state codes, each with a dwell-time stamp.
- Supports a trigger-and-freeze capture with a post-trigger window, random-access readout, and a packed 32-bit legacy debug word for the register map.
- Sits beside the FSM in the st_clk_i domain; purely observational, with no back-pressure on the FSM.

Parameters:
- ST_W, 6, state code width.
- DEPTH, 8, history entries (≥2).
- TS_W, 16, dwell counter width.
- PACK_N, 5, entries packed into debug_dt_o; PACK_N*ST_W ≤ 32.
- RST_CODE, 62, fill code for empty history entries 1..DEPTH-1.
- CNT_W, 16, transition counter width.

Ports:
- st_clk_i  in  1  clock
- st_rst_ni  in  1  asynchronous active-low reset
- current_st_i  in  ST_W  encoded current state
- next_st_i  in  ST_W  encoded next state
- clear_i  in  1  re-arm and flush history (1-cycle pulse)
- trig_en_i  in  1  enable trigger match
- trig_code_i  in  ST_W  state code that fires the trigger
- post_n_i  in  8  transitions still captured after the trigger
- rd_idx_i  in  $clog2(DEPTH)  history index; 0 is newest
- rd_code_o  out  ST_W  code at rd_idx_i
- rd_dwell_o  out  TS_W  dwell at rd_idx_i
- debug_dt_o  out  32  {entry0..entry(PACK_N-1)} codes, entry0 in the MSBs of the packed field, upper unused bits 0
- trans_cnt_o  out  CNT_W  transitions since clear, saturating
- ovf_o  out  1  more than DEPTH-1 transitions since clear (oldest entries lost)
- frozen_o  out  1  capture frozen
- trig_o  out  1  trigger has fired since clear

Behaviour:
- Clock and reset: one clock, st_clk_i. Reset st_rst_ni is asynchronous and active-low.
- Reset values:
  - entry0 = {0, 0}; entries 1..DEPTH-1 = {RST_CODE, 0}.
  - dwell_cnt = 0, trans_cnt_o = 0, ovf_o = 0, frozen_o = 0, trig_o = 0.
  - rd_code_o = 0, rd_dwell_o = 0, post counter = 0, FSM = RUN.
- change = (current_st_i != next_st_i), evaluated every cycle.
- Dwell counter:
  - Increments every cycle without change while not FROZEN, saturating at 2^TS_W-1.
  - Set to 0 on a recorded change.
  - Entry0's dwell field reads the live dwell_cnt.
- Recorded change (FSM in RUN or POST):
  - entry[k] <= entry[k-1] for k ≥ 2.
  - entry1 <= {entry0.code, dwell_cnt}.
  - entry0 <= {next_st_i, 0}.
  - All updates take effect on the same edge.
- trans_cnt_o increments on every change in every FSM state, saturating.
- ovf_o sets when a change arrives with trans_cnt_o ≥ DEPTH-1 while not FROZEN; it is sticky until clear or reset.
- FSM states and transitions:
  - RUN → POST on a recorded change with trig_en_i=1 and next_st_i == trig_code_i. Sets trig_o and loads post counter = post_n_i. If post_n_i = 0, go directly to FROZEN; the trigger entry is still recorded.
  - POST: each recorded change decrements the post counter; the change that brings it to 0 is recorded, then the FSM enters FROZEN.
  - FROZEN: no history shifts and dwell_cnt holds; frozen_o = 1. Exits only via clear_i.
  - Any state + clear_i → RUN.
- clear_i:
  - Entries 1..DEPTH-1 ← {RST_CODE, 0}; entry0 ← {next_st_i, 0}.
  - dwell_cnt, trans_cnt_o, ovf_o, trig_o, frozen_o ← 0.
  - clear_i has priority over a simultaneous change, trigger or freeze; the change that cycle is not counted.
- trig_en_i low in RUN: triggers are ignored. trig_en_i is not sampled in POST or FROZEN.
- Readout:
  - Registered, latency 1 cycle from rd_idx_i.
  - Index ≥ DEPTH (non-power-of-2 DEPTH) returns {RST_CODE, 0}.
  - Readout during a shift returns the pre-shift contents.
- debug_dt_o: combinational from entries, no extra latency. With default parameters it is bit-identical to the existing 5×6-bit debug word, including 62 fill after reset.
- Reset mid-POST: all state returns to reset values immediately (asynchronous); no partial freeze is retained.

Decomposition:
- qnet_pkg gains:
  - the state-code encoding function (TYPE_QNET_CMD → ST_W code, ST_ERROR = 63);
  - constant QNET_DBG_FILL = 62;
  - typedef for the trace FSM enum {RUN, POST, FROZEN}.
- One sub-module: qnet_trace_hist (DEPTH×(ST_W+TS_W) shift register with load/clear/read mux).
- The top holds change detection, dwell and transition counters, the FSM, and packing.

Test Plan:
- Reset, no changes → debug_dt_o = 0x00FBEFBE for the 30-bit pattern {0,62,62,62,62}; trans_cnt_o = 0; rd_idx_i=3 → code 62 one cycle later.
- Codes 1→2→3 with 10 and 4 cycle holds → entry0=3, entry1={2,4}, entry2={1,10}; trans_cnt_o=2; ovf_o=0.
- 9 changes with DEPTH=8 → ovf_o=1 on the 8th; the oldest code is gone; trans_cnt_o=9.
- trig_code_i=42, post_n_i=2, changes to 42,7,9,11 → trig_o at 42; frozen_o after 9; entry0=9; 11 not recorded; trans_cnt_o counts 4.
- Hold one state for 70000 cycles with TS_W=16 → dwell saturates at 65535.
- clear_i coincident with a change to 5 → history = {next_st_i, 62…}; trans_cnt_o=0; FSM=RUN; ovf_o=0.
